// File: rtl/bcd_pkg.sv
// bcd_pkg
//   Constants and state encoding shared by the BCD-to-binary converter and
//   its per-digit corrector.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // Largest legal value of one BCD digit.
    localparam logic [3:0] BCD_DIGIT_MAX     = 4'd9;
    // Digits at or above this after a right shift need correcting.
    localparam logic [3:0] BCD_SUB_THRESHOLD = 4'd8;
    localparam logic [3:0] BCD_SUB_VALUE     = 4'd3;

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// bcd_to_binary_seq_if
//   Start/busy/done handshake plus data bus of the BCD-to-binary converter.
//   master : requester (drives start, bcd_in; reads busy, done, err, bin_out)
//   slave  : converter (reads start, bcd_in; drives busy, done, err, bin_out)
interface bcd_to_binary_seq_if #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [BIN_W-1:0]      bin_out;

    modport master (
        output start, bcd_in,
        input  busy, done, err, bin_out
    );

    modport slave (
        input  start, bcd_in,
        output busy, done, err, bin_out
    );
endinterface

// File: rtl/bcd_digit_sub3.sv
// bcd_digit_sub3
//   Combinational corrector for one BCD digit of the reverse double dabble:
//   subtracts 3 when the digit is 8 or more, otherwise passes it through.
//   Mirror of the add-3 corrector used by the binary-to-BCD encoder.
//   digit     : 4-bit digit after the right shift
//   corrected : 4-bit corrected digit
module bcd_digit_sub3
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] corrected
);

    // digit >= 8 guarantees digit - 3 >= 5, so no underflow is possible.
    assign corrected = (digit >= BCD_SUB_THRESHOLD) ? digit - BCD_SUB_VALUE : digit;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq
//   Sequential BCD-to-binary converter (reverse double dabble), one shift
//   step per clock. Inputs with a digit above 9 skip conversion and report err.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : slave side of the start/busy/done handshake
//           (start, bcd_in in; busy, done, err, bin_out out)
//   Latency: start accepted at edge k, done pulses after edge k+BIN_W+1
//   (k+1 for an invalid input).
module bcd_to_binary_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                clk,
    input  logic                reset,
    bcd_to_binary_seq_if.slave  bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

    state_t             state;
    logic [BCD_W-1:0]   bcd_reg;
    logic [BIN_W-1:0]   bin_reg;
    logic [CNT_W-1:0]   count;
    logic               err_pend;

    logic [BCD_W+BIN_W-1:0] shifted;
    logic [BCD_W-1:0]       bcd_corr;
    logic                   bad_digit;

    // Whole-register right shift; bcd_reg[0] drops into the bin_reg MSB.
    assign shifted = {bcd_reg, bin_reg} >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_sub3 u_sub3 (
            .digit     (shifted[BIN_W + 4*g +: 4]),
            .corrected (bcd_corr[4*g +: 4])
        );
    end

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd_in[4*i +: 4] > BCD_DIGIT_MAX) begin
                bad_digit = 1'b1;
            end
        end
    end

    // done/err/bin_out are registered on the edge that leaves DONE, so the
    // done pulse lands in the following IDLE cycle, where a held start is
    // accepted again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bcd_reg     <= '0;
            bin_reg     <= '0;
            count       <= '0;
            err_pend    <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.err     <= 1'b0;
            bus.bin_out <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.busy <= 1'b1;
                        if (bad_digit) begin
                            err_pend <= 1'b1;
                            state    <= DONE;
                        end else begin
                            err_pend <= 1'b0;
                            bcd_reg  <= bus.bcd_in;
                            bin_reg  <= '0;
                            count    <= '0;
                            state    <= CONV;
                        end
                    end
                end
                CONV: begin
                    bcd_reg <= bcd_corr;
                    bin_reg <= shifted[BIN_W-1:0];
                    count   <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bus.done    <= 1'b1;
                    bus.err     <= err_pend;
                    bus.bin_out <= err_pend ? '0 : bin_reg;
                    bus.busy    <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Every BCD bit must have been shifted out by the time DONE is reached.
    a_bcd_drained: assert property (@(posedge clk) disable iff (reset)
        (state == DONE) |-> (bcd_reg == '0));

endmodule
